// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter in front of one shared combinational ALU: latch winner's operands,
// hold them EXEC_CYCLES cycles, then register the result as a response held until accepted.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (req0 always wins a tie).
module alu_share_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       aluc0,
    input  logic [3:0]       aluc1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    input  logic             alu_pos,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_z,
    output logic             rsp_pos,
    output logic             busy
);

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [3:0]       op_aluc_q, op_aluc_d;
    logic             id_next_q, id_next_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_pos_q, rsp_pos_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             win_valid;
    logic             win_id;

    // Winner selection; only meaningful while idle, grants are masked by state below.
    always_comb begin
        win_valid = req0 | req1;
        win_id    = 1'b0;
        if (req0 && req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            win_id = 1'b0;
`else
            win_id = ~last_q;
`endif
        end else begin
            win_id = req1;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE && win_valid) begin
            gnt0 = ~win_id;
            gnt1 = win_id;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_aluc_d   = op_aluc_q;
        id_next_d   = id_next_q;
        last_d      = last_q;
        rsp_s_d     = rsp_s_q;
        rsp_z_d     = rsp_z_q;
        rsp_pos_d   = rsp_pos_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    op_a_d    = win_id ? a1 : a0;
                    op_b_d    = win_id ? b1 : b0;
                    op_aluc_d = win_id ? aluc1 : aluc0;
                    id_next_d = win_id;
                    last_d    = win_id;
                    cnt_d     = CNT_INIT;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_s_d     = alu_s;
                    rsp_z_d     = alu_z;
                    rsp_pos_d   = alu_pos;
                    rsp_id_d    = id_next_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_aluc_q   <= '0;
            id_next_q   <= 1'b0;
            last_q      <= 1'b1;
            rsp_s_q     <= '0;
            rsp_z_q     <= 1'b0;
            rsp_pos_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_aluc_q   <= op_aluc_d;
            id_next_q   <= id_next_d;
            last_q      <= last_d;
            rsp_s_q     <= rsp_s_d;
            rsp_z_q     <= rsp_z_d;
            rsp_pos_q   <= rsp_pos_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // ALU inputs come straight from the op registers so they never toggle outside a grant.
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_aluc  = op_aluc_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_pos   = rsp_pos_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule
